// File: rtl/ic_shift_reg_universal.sv
// Universal shift register with direct ops, counted bursts (IDLE/RUN/DONE) and tri-state output.
// All state advances on the falling edge of iClk; iClrN clears everything asynchronously.
module ic_shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             iClk,
    input  logic             iClrN,
    input  logic             iEn,
    input  logic             iOE_N,
    input  logic [2:0]       iOp,
    input  logic             iSerLo,
    input  logic             iSerHi,
    input  logic [WIDTH-1:0] iData,
    input  logic             iStart,
    input  logic [CW-1:0]    iCount,
    output logic [WIDTH-1:0] oData,
    output logic [WIDTH-1:0] oQ,
    output logic             oMsb,
    output logic             oLsb,
    output logic             oBusy,
    output logic             oDone
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} stateT;

    stateT            state, stateNext;
    logic [WIDTH-1:0] q;
    logic [2:0]       latOp, opSel;
    logic [CW-1:0]    remCnt;
    logic             exec, latch, burstOp;

    function automatic logic [WIDTH-1:0] applyOp(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                                 input logic lo, input logic hi,
                                                 input logic [WIDTH-1:0] ld);
        case (op)
            3'b001:  applyOp = {d[WIDTH-2:0], lo};
            3'b010:  applyOp = {hi, d[WIDTH-1:1]};
            3'b011:  applyOp = {d[WIDTH-2:0], d[WIDTH-1]};
            3'b100:  applyOp = {d[0], d[WIDTH-1:1]};
            3'b101:  applyOp = {d[WIDTH-1], d[WIDTH-1:1]};
            3'b110:  applyOp = ld;
            3'b111:  applyOp = '0;
            default: applyOp = d;
        endcase
    endfunction

    assign burstOp = (iOp >= 3'd1) && (iOp <= 3'd5);

    always_ff @(negedge iClk or negedge iClrN) begin
        if (!iClrN) state <= IDLE;
        else        state <= stateNext;
    end

    // Only shift/rotate ops may be bursted; hold/load/clear with iStart fall through to direct mode.
    always_comb begin
        stateNext = state;
        exec      = 1'b0;
        latch     = 1'b0;
        opSel     = iOp;
        case (state)
            IDLE: if (iEn) begin
                if (iStart && burstOp) begin
                    latch     = 1'b1;
                    stateNext = (iCount == '0) ? DONE : RUN;
                end else begin
                    exec = 1'b1;
                end
            end
            RUN: if (iEn) begin
                exec  = 1'b1;
                opSel = latOp;
                if (remCnt == CW'(1)) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state == RUN);
        oDone = (state == DONE);
    end

    always_ff @(negedge iClk or negedge iClrN) begin
        if (!iClrN) begin
            q      <= '0;
            latOp  <= '0;
            remCnt <= '0;
        end else begin
            if (exec)  q <= applyOp(opSel, q, iSerLo, iSerHi, iData);
            if (latch) begin
                latOp  <= iOp;
                remCnt <= iCount;
            end else if (exec && state == RUN) begin
                remCnt <= remCnt - CW'(1);
            end
        end
    end

    assign oQ    = q;
    assign oMsb  = q[WIDTH-1];
    assign oLsb  = q[0];
    assign oData = iOE_N ? {WIDTH{1'bz}} : q;

endmodule

// File: tb/tb_ic_shift_reg_universal.sv
// Randomized bench for ic_shift_reg_universal against a behavioural burst/shift model,
// plus hand-computed sequences that pin the model.
module tb_ic_shift_reg_universal;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          iClk, iClrN, iEn, iOE_N, iSerLo, iSerHi, iStart;
    logic [2:0]    iOp;
    logic [W-1:0]  iData;
    logic [CW-1:0] iCount;
    wire  [W-1:0]  oData;
    logic [W-1:0]  oQ;
    logic          oMsb, oLsb, oBusy, oDone;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mQ;
    bit           mBusy, mDone;
    int           mLeft, mOp;

    ic_shift_reg_universal #(.WIDTH(W)) dut (
        .iClk(iClk), .iClrN(iClrN), .iEn(iEn), .iOE_N(iOE_N), .iOp(iOp),
        .iSerLo(iSerLo), .iSerHi(iSerHi), .iData(iData), .iStart(iStart), .iCount(iCount),
        .oData(oData), .oQ(oQ), .oMsb(oMsb), .oLsb(oLsb), .oBusy(oBusy), .oDone(oDone)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkZ(input string name);
        logic [W-1:0] zv;
        zv = {W{1'bz}};
        checks++;
        if (!(oData === zv || oData === '0)) begin
            errors++;
            $display("FAIL %s: got %h expected released bus at %0t", name, oData, $time);
        end
    endtask

    // Register value after one operation, expressed as plain integer arithmetic.
    function automatic logic [W-1:0] model(input int op, input logic [W-1:0] q, input bit lo,
                                           input bit hi, input logic [W-1:0] d);
        int v, top;
        v   = int'(q);
        top = 1 << (W - 1);
        case (op)
            1:       v = (v * 2 + int'(lo)) % (2 * top);
            2:       v = v / 2 + int'(hi) * top;
            3:       v = (v * 2) % (2 * top) + v / top;
            4:       v = v / 2 + (v % 2) * top;
            5:       v = v / 2 + (v / top) * top;
            6:       v = int'(d);
            7:       v = 0;
            default: v = v;
        endcase
        return v[W-1:0];
    endfunction

    always @(negedge iClk or negedge iClrN) begin
        if (!iClrN) begin
            mQ <= '0; mBusy <= 0; mDone <= 0; mLeft <= 0;
        end else if (mDone) begin
            mDone <= 0;
        end else if (mBusy) begin
            if (iEn) begin
                mQ    <= model(mOp, mQ, iSerLo, iSerHi, iData);
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin mBusy <= 0; mDone <= 1; end
            end
        end else if (iEn) begin
            if (iStart && iOp >= 3'd1 && iOp <= 3'd5) begin
                if (iCount == 0) mDone <= 1;
                else begin mBusy <= 1; mLeft <= int'(iCount); mOp <= int'(iOp); end
            end else begin
                mQ <= model(int'(iOp), mQ, iSerLo, iSerHi, iData);
            end
        end
    end

    // Every rising edge sits midway between active edges, so outputs are settled.
    always @(posedge iClk) begin
        chk("oQ", oQ, mQ);
        chk("oMsb", oMsb, mQ[W-1]);
        chk("oLsb", oLsb, mQ[0]);
        chk("oBusy", oBusy, mBusy);
        chk("oDone", oDone, mDone);
        if (!iOE_N) chk("oData", oData, mQ);
        else        chkZ("oDataZ");
    end

    task automatic cyc(input bit en, input int op, input bit st = 0, input int cnt = 0,
                       input int data = 0, input bit lo = 0, input bit hi = 0);
        @(posedge iClk);
        #2;
        iEn = en; iOp = op[2:0]; iStart = st; iCount = cnt[CW-1:0];
        iData = data[W-1:0]; iSerLo = lo; iSerHi = hi;
        @(negedge iClk);
        #1;
    endtask

    task automatic rstPulse();
        @(posedge iClk);
        #2;
        iEn = 0; iClrN = 0;
        #1;
        chk("rst oQ", oQ, 0);
        chk("rst oBusy", oBusy, 0);
        chk("rst oDone", oDone, 0);
        #1 iClrN = 1;
    endtask

    initial begin
        iClrN = 0; iEn = 0; iOE_N = 0; iOp = 0; iSerLo = 0; iSerHi = 0;
        iData = 0; iStart = 0; iCount = 0;
        #12;
        chk("reset oQ", oQ, 0);
        chk("reset oBusy", oBusy, 0);
        chk("reset oDone", oDone, 0);
        @(posedge iClk); #2 iClrN = 1;

        cyc(1, 6, 0, 0, 'hA5);
        chk("load", oQ, 'hA5);
        cyc(1, 1, 0, 0, 0, 1);
        chk("shl oQ", oQ, 'h4B);
        chk("shl msb", oMsb, 0);
        chk("shl lsb", oLsb, 1);

        cyc(1, 6, 0, 0, 'h81);
        cyc(1, 4, 1, 3);
        chk("ror start", {oBusy, oQ}, {1'b1, 8'h81});
        cyc(1, 0);
        chk("ror 1", {oBusy, oDone, oQ}, {2'b10, 8'hC0});
        cyc(1, 0);
        chk("ror 2", {oBusy, oDone, oQ}, {2'b10, 8'h60});
        cyc(1, 0);
        chk("ror 3", {oBusy, oDone, oQ}, {2'b01, 8'h30});
        cyc(1, 0);
        chk("ror idle", {oBusy, oDone, oQ}, {2'b00, 8'h30});

        cyc(1, 6, 0, 0, 'h80);
        cyc(1, 5, 1, 2);
        cyc(1, 0);
        cyc(1, 0);
        chk("asr 2", {oBusy, oDone, oQ}, {2'b01, 8'hE0});
        cyc(1, 0);
        cyc(1, 5, 1, 0);
        chk("cnt0 done", {oBusy, oDone, oQ}, {2'b01, 8'hE0});
        cyc(1, 0);
        chk("cnt0 idle", {oBusy, oDone}, 2'b00);

        cyc(1, 6, 0, 0, 'h01);
        cyc(1, 1, 1, 4);
        cyc(1, 0);
        chk("pause pre", {oBusy, oQ}, {1'b1, 8'h02});
        cyc(0, 7, 1, 2);
        cyc(0, 7, 1, 2);
        chk("pause hold", {oBusy, oDone, oQ}, {2'b10, 8'h02});
        cyc(1, 6, 1, 1, 'hFF);
        chk("resume 1", {oBusy, oQ}, {1'b1, 8'h04});
        cyc(1, 6, 1, 1, 'hFF);
        cyc(1, 6, 1, 1, 'hFF);
        chk("resume end", {oBusy, oDone, oQ}, {2'b01, 8'h10});
        cyc(1, 0);

        cyc(1, 6, 0, 0, 'h55);
        cyc(1, 2, 1, 5);
        cyc(1, 0);
        chk("abort pre", {oBusy, oQ}, {1'b1, 8'h2A});
        rstPulse();
        cyc(0, 0);
        chk("abort no done", {oBusy, oDone, oQ}, {2'b00, 8'h00});
        cyc(1, 0);
        chk("abort after", {oBusy, oDone}, 2'b00);

        iOE_N = 1;
        cyc(1, 6, 0, 0, 'h3C);
        chkZ("oe off load");
        chk("oe off oQ", oQ, 'h3C);
        cyc(1, 1);
        chkZ("oe off shift");
        chk("oe off oQ2", oQ, 'h78);
        iOE_N = 0;
        #1 chk("oe on", oData, 'h78);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 63) == 0) rstPulse();
            iOE_N = ($urandom_range(0, 3) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) == 0,
                $urandom_range(0, W), $urandom_range(0, 255), $urandom_range(0, 1),
                $urandom_range(0, 1));
        end

        @(posedge iClk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
